// File: rtl/sram_fifo_pkg.sv
// Shared types and helpers for the SRAM-backed FIFO.
// Parity option: SRAM_FIFO_PARITY_EN.
package sram_fifo_pkg;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_ONE   = 2'd1,
    PF_TWO   = 2'd2
  } pf_t;

  localparam int PAR_MAXW = 1024;

  function automatic int adr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Words narrower than PAR_MAXW are zero-extended by the caller.
  function automatic logic parity(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_fifo_ram.sv
// Behavioural 1-write/1-read array with a registered read port.
// Drop-in point for a hard SRAM macro.
module sram_fifo_ram
  import sram_fifo_pkg::*;
#(
  parameter int WORD  = 8,
  parameter int ADDR  = 3,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [WORD-1:0] wdata,
  input  logic            re,
  input  logic [ADDR-1:0] raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_fifo.sv
// Single-clock FIFO over a registered-read array with a 2-entry prefetch.
// Optional stored parity: define SRAM_FIFO_PARITY_EN.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 512,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     afull,
  output logic                     out_perr
);

  localparam int AW = adr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef SRAM_FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] mem_cnt;
  logic          rd_pend;
  logic          rdy_en;
  pf_t           pf;
  logic [MW-1:0] b0;
  logic [MW-1:0] b1;
  logic [MW-1:0] wword;
  logic [MW-1:0] rword;
  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    occ;

  assign in_ready  = rdy_en && (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign out_valid = (pf != PF_EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_data  = b0[WIDTH-1:0];
  assign afull     = (count >= CW'(AFULL_TH));

  // A pop this cycle frees a slot, so a read may be issued into it.
  assign occ   = 2'(pf) + {1'b0, rd_pend} - {1'b0, pop};
  assign issue = (mem_cnt != '0) && (occ < 2'd2);

`ifdef SRAM_FIFO_PARITY_EN
  assign wword    = {parity(PAR_MAXW'(in_data)), in_data};
  assign out_perr = out_valid &&
    (b0[WIDTH] != parity(PAR_MAXW'(b0[WIDTH-1:0])));
`else
  assign wword    = in_data;
  assign out_perr = 1'b0;
`endif

  sram_fifo_ram #(
    .WORD  (MW),
    .ADDR  (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wword),
    .re    (issue),
    .raddr (rptr),
    .rdata (rword)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
      rdy_en  <= 1'b0;
      count   <= '0;
    end else begin
      rdy_en  <= 1'b1;
      rd_pend <= issue;
      if (push)  wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      unique case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: ;
      endcase
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pf <= PF_EMPTY;
      b0 <= '0;
      b1 <= '0;
    end else begin
      unique case (1'b1)
        (rd_pend && pop): begin
          if (pf == PF_TWO) begin
            b0 <= b1;
            b1 <= rword;
          end else begin
            b0 <= rword;
          end
        end
        (rd_pend && !pop): begin
          if (pf == PF_EMPTY) begin
            b0 <= rword;
            pf <= PF_ONE;
          end else begin
            b1 <= rword;
            pf <= PF_TWO;
          end
        end
        (!rd_pend && pop): begin
          b0 <= b1;
          pf <= (pf == PF_TWO) ? PF_ONE : PF_EMPTY;
        end
        default: ;
      endcase
    end
  end

endmodule
